bram_arb: RTL
=============

Name: bram_arb

Overview:
- Two-master arbiter that shares the single-port 32-bit block RAM between the CPU (master 0) and a DMA/boot-loader engine (master 1).
- Sits between the masters and the bram_mem instance.
- Grants one access per cycle, using sticky ownership with a burst limit so neither master starves.
- Stalls the CPU through its hold input and returns read data with a registered valid strobe that matches the 1-cycle BRAM latency.

Parameters:
- ADDR_W, 12, word-address width of the BRAM.
- MAX_BURST, 8, maximum consecutive grants to one master while the other is requesting; range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m0_req  in  1  CPU requests an access this cycle.
- m0_wen  in  4  CPU byte write mask; 0 = read.
- m0_addr  in  ADDR_W  CPU word address.
- m0_wdata  in  32  CPU write data.
- m0_hold  out  1  stall to CPU; = m0_req & ~m0_gnt.
- m0_gnt  out  1  CPU access issued this cycle.
- m0_rvalid  out  1  read data for master 0 valid on m0_rdata.
- m0_rdata  out  32  read data to CPU.
- m1_req, m1_wen, m1_addr, m1_wdata  in  1/4/ADDR_W/32  DMA request, same meaning as m0_*.
- m1_gnt  out  1  DMA access issued this cycle.
- m1_rvalid  out  1  read data for master 1 valid.
- m1_rdata  out  32  read data to DMA.
- mem_wen  out  4  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM registered read data (valid 1 cycle after address).

Behaviour:
- State registers:
  - owner: 1 bit, reset 0.
  - burst_cnt: 8 bits, reset 0.
  - rd_pend: 1 bit, reset 0.
  - rd_who: 1 bit, reset 0.
- Grant logic (combinational from req and state):
  - Neither requesting: no grant.
  - Exactly one requesting: grant it.
  - Both requesting: grant owner, unless burst_cnt == MAX_BURST; in that case grant ~owner.
- Grants are one-hot or zero. m0_gnt/m1_gnt have no registered delay; the masters must hold their request fields stable while not granted.
- Memory outputs:
  - mem_addr, mem_wdata and mem_wen come from the granted master.
  - With no grant, mem_wen = 0 and mem_addr/mem_wdata = master 0's values.
- State update on every clock edge with a grant g:
  - owner <= g.
  - If g != previous owner, or the other master is not requesting: burst_cnt <= 1.
  - Otherwise: burst_cnt <= burst_cnt + 1, saturating at MAX_BURST.
  - No grant: owner holds; burst_cnt <= 0.
- Read return:
  - A granted access with wen == 0 sets rd_pend <= 1 and rd_who <= g for the next cycle. Otherwise rd_pend <= 0.
  - m0_rvalid = rd_pend & ~rd_who; m1_rvalid = rd_pend & rd_who.
  - m0_rdata = m1_rdata = mem_rdata (both unqualified; consumers qualify with rvalid).
  - Back-to-back reads from alternating masters are legal: one return per cycle, in issue order.
- Writes complete in the grant cycle. No write acknowledge beyond gnt.
- A read issued in cycle N to an address written in cycle N-1 returns the new data (BRAM behaviour; no bypass needed).
- Reset:
  - All outputs are 0 while reset is low: gnt, rvalid, mem_wen, m0_hold. m0_hold is forced 0 in reset.
  - Reset asserted mid-access drops the pending read; no rvalid after deassertion.
  - The first cycle after release uses owner = 0, so the CPU wins a tie.
- MAX_BURST = 1 gives strict alternation under contention.

Decomposition:
- Shared package/header holds the BRAM geometry constants (word width 32, ADDR_W default 12) and the master index encodings (MST_CPU = 0, MST_DMA = 1), for reuse by the SoC top and the DMA engine.
- One natural sub-module: bram_arb_rr_sel, which computes grant and next burst_cnt from req, owner and burst_cnt. It is purely combinational and is reused if the master count grows.
- The registers stay in bram_arb.

Test Plan:
- Reset low with m0_req = 1 → m0_gnt = 0, m0_hold = 0, mem_wen = 0. Release reset → same cycle m0_gnt = 1.
- Only m1 reads addr 0x010 (BRAM holds 0xDEADBEEF) → m1_gnt at cycle N; m1_rvalid = 1 and m1_rdata = 0xDEADBEEF at N+1; m0_rvalid stays 0.
- Both requesting continuously, MAX_BURST = 8, owner = 0 → grants 8×m0, 8×m1, 8×m0…; m0_hold = 1 exactly during the m1 runs.
- m0 writes 0x11223344 mask 4'b0101 to addr 5 while m1 is idle; next cycle m1 reads addr 5 → m1_rdata = old[31:24], 0x22, old[15:8], 0x44.
- Alternating reads m0 @1, m1 @2, m0 @3 on consecutive cycles with MAX_BURST = 1 → rvalid sequence m0, m1, m0 with matching data, no gaps.
- Reset asserted the cycle after a granted m1 read → m1_rvalid never asserts; after release burst_cnt = 0 and owner = 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared BRAM geometry and master encodings for the block-RAM arbiter, SoC top and DMA engine.
package bram_arb_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned N_MST      = 2;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bram_arb_rr_sel.sv
// Grant selection with sticky ownership and a burst limit; purely combinational.
module bram_arb_rr_sel
  import bram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic [N_MST-1:0] req_i,
  input  mst_e             owner_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             gnt_vld_o,
  output mst_e             gnt_idx_o,
  output logic [N_MST-1:0] gnt_o,
  output logic [CNT_W-1:0] burst_cnt_d_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic other_req;

  always_comb begin
    gnt_vld_o     = 1'b0;
    gnt_idx_o     = owner_i;
    burst_cnt_d_o = '0;
    other_req     = 1'b0;

    case (req_i)
      2'b01: begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = MST_CPU;
      end
      2'b10: begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = MST_DMA;
      end
      2'b11: begin
        gnt_vld_o = 1'b1;
        // Owner keeps the RAM until it has used up its burst allowance.
        gnt_idx_o = (burst_cnt_i == MAX_CNT) ? mst_e'(~owner_i) : owner_i;
      end
      default: ;
    endcase

    other_req = (gnt_idx_o == MST_CPU) ? req_i[1] : req_i[0];

    if (gnt_vld_o) begin
      if ((gnt_idx_o != owner_i) || !other_req) begin
        burst_cnt_d_o = CNT_W'(1);
      end else begin
        burst_cnt_d_o = sat_inc(burst_cnt_i, MAX_CNT);
      end
    end
  end

  assign gnt_o = {gnt_vld_o & (gnt_idx_o == MST_DMA),
                  gnt_vld_o & (gnt_idx_o == MST_CPU)};

endmodule

// File: rtl/bram_arb.sv
// Two-master arbiter sharing one single-port 32-bit BRAM between the CPU and the DMA engine.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [BE_W-1:0]   m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_hold,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [BE_W-1:0]   m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [BE_W-1:0]   mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [N_MST-1:0] req;
  logic             gnt_vld;
  mst_e             gnt_idx;
  logic [N_MST-1:0] gnt;
  logic [BE_W-1:0]  sel_wen;

  mst_e             owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  mst_e             rd_who_q, rd_who_d;

  // Requests are masked in reset so grants, write enables and hold all read 0.
  assign req = {m1_req, m0_req} & {N_MST{reset}};

  bram_arb_rr_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_sel (
    .req_i         (req),
    .owner_i       (owner_q),
    .burst_cnt_i   (burst_cnt_q),
    .gnt_vld_o     (gnt_vld),
    .gnt_idx_o     (gnt_idx),
    .gnt_o         (gnt),
    .burst_cnt_d_o (burst_cnt_d)
  );

  always_comb begin
    sel_wen   = m0_wen;
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (gnt_vld && (gnt_idx == MST_DMA)) begin
      sel_wen   = m1_wen;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
    mem_wen   = gnt_vld ? sel_wen : '0;

    owner_d   = gnt_vld ? gnt_idx : owner_q;
    rd_pend_d = gnt_vld && (sel_wen == '0);
    rd_who_d  = rd_pend_d ? gnt_idx : rd_who_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= MST_CPU;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_who_q    <= MST_CPU;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_who_q    <= rd_who_d;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_hold   = m0_req & ~gnt[0] & reset;
  assign m0_rvalid = rd_pend_q & (rd_who_q == MST_CPU);
  assign m1_rvalid = rd_pend_q & (rd_who_q == MST_DMA);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule
